// File: rtl/soft_error_event_logger.sv
// soft_error_event_logger
// Rising-edge event logger for the per-bank soft-error hub flags.
// Per-bank saturating counters for channels A and B, plus a timestamped record
// FIFO (first-word-fall-through) drained over a valid/ready stream.
// Optional build macro: SOFT_ERR_GLITCH_FILTER_EN -- an edge only qualifies
// after the flag has been high for two consecutive cycles.
module soft_error_event_logger #(
  parameter int ERRSIG_ID_num = 7,
  parameter int TS_W          = 32,
  parameter int CNT_W         = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int REC_W         = TS_W + 2*ERRSIG_ID_num
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [ERRSIG_ID_num-1:0]          i_err_A,
  input  logic [ERRSIG_ID_num-1:0]          i_err_B,
  input  logic                              i_clr,
  input  logic [$clog2(ERRSIG_ID_num)-1:0]  i_rd_sel,
  output logic [CNT_W-1:0]                  o_cnt_A,
  output logic [CNT_W-1:0]                  o_cnt_B,
  output logic                              o_rec_valid,
  input  logic                              i_rec_ready,
  output logic [REC_W-1:0]                  o_rec_data,
  output logic                              o_overflow,
  output logic [CNT_W-1:0]                  o_drop_cnt
);

  localparam int N  = ERRSIG_ID_num;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

  // Saturating +1; holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [TS_W-1:0]  ts;
  logic [N-1:0]     err_a_d, err_b_d;
  logic [N-1:0]     rise_a, rise_b;
`ifdef SOFT_ERR_GLITCH_FILTER_EN
  logic [N-1:0]     err_a_dd, err_b_dd;
`endif

  logic             vld_p1;
  logic [N-1:0]     rise_a_p1, rise_b_p1;
  logic [TS_W-1:0]  ts_p1;

  logic [CNT_W-1:0] cnt_a [N];
  logic [CNT_W-1:0] cnt_b [N];

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, push, pop, drop;

  // ---- Stage 0: edge detect against the delayed flags ----

  // Delayed copies of the flags; cleared by reset so a flag already high at
  // release is seen as a fresh edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      err_a_d  <= '0;
      err_b_d  <= '0;
`ifdef SOFT_ERR_GLITCH_FILTER_EN
      err_a_dd <= '0;
      err_b_dd <= '0;
`endif
    end else begin
      err_a_d  <= i_err_A;
      err_b_d  <= i_err_B;
`ifdef SOFT_ERR_GLITCH_FILTER_EN
      err_a_dd <= err_a_d;
      err_b_dd <= err_b_d;
`endif
    end
  end

  // Rising-edge qualification for the current cycle.
  always_comb begin
`ifdef SOFT_ERR_GLITCH_FILTER_EN
    rise_a = i_err_A & err_a_d & ~err_a_dd;
    rise_b = i_err_B & err_b_d & ~err_b_dd;
`else
    rise_a = i_err_A & ~err_a_d;
    rise_b = i_err_B & ~err_b_d;
`endif
  end

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst) ts <= '0;
    else        ts <= ts + TS_ONE;
  end

  // ---- Stage 1: capture edges with the timestamp of their cycle ----

  // Capture valid: only set when the cycle held at least one new event.
  always_ff @(posedge i_clk) begin
    if (!i_rst) vld_p1 <= 1'b0;
    else        vld_p1 <= |{rise_a, rise_b};
  end

  // Capture payload; qualified by vld_p1, so it needs no reset.
  always_ff @(posedge i_clk) begin
    rise_a_p1 <= rise_a;
    rise_b_p1 <= rise_b;
    ts_p1     <= ts;
  end

  // ---- Stage 2: counter update and record push ----

  // A full FIFO still accepts a record when the head leaves in the same cycle.
  always_comb begin
    full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    o_rec_valid = (wr_ptr != rd_ptr);
    pop         = o_rec_valid & i_rec_ready;
    push        = vld_p1 & (~full | pop);
    drop        = vld_p1 & full & ~pop;
    o_rec_data  = o_rec_valid ? mem[rd_ptr[AW-1:0]] : '0;
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Record storage; pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ts_p1, rise_b_p1, rise_a_p1};
  end

  // Per-bank event counters; clear wins over a coincident increment.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N; i++) begin
      if (!i_rst || i_clr) begin
        cnt_a[i] <= '0;
        cnt_b[i] <= '0;
      end else if (vld_p1) begin
        if (rise_a_p1[i]) cnt_a[i] <= sat_inc(cnt_a[i]);
        if (rise_b_p1[i]) cnt_b[i] <= sat_inc(cnt_b[i]);
      end
    end
  end

  // Sticky overflow flag and saturating drop count.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      o_drop_cnt <= sat_inc(o_drop_cnt);
    end
  end

  // Registered counter readout; an index past the last bank reads as zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_cnt_A <= '0;
      o_cnt_B <= '0;
    end else if (int'(i_rd_sel) < N) begin
      o_cnt_A <= cnt_a[i_rd_sel];
      o_cnt_B <= cnt_b[i_rd_sel];
    end else begin
      o_cnt_A <= '0;
      o_cnt_B <= '0;
    end
  end

endmodule

// File: tb/tb_soft_error_event_logger.sv
// Testbench for soft_error_event_logger: scoreboard of expected records plus a
// small event/counter model. A second instance with 4-bit counters shares the
// stimulus to exercise saturation.
module tb_soft_error_event_logger;

  localparam int N     = 7;
  localparam int TSW   = 32;
  localparam int RW    = TSW + 2*N;
  localparam int DEPTH = 16;
`ifdef SOFT_ERR_GLITCH_FILTER_EN
  localparam int LAT = 3;
  localparam int PW  = 2;
`else
  localparam int LAT = 2;
  localparam int PW  = 1;
`endif

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [N-1:0]  i_err_A = '0, i_err_B = '0;
  logic          i_clr = 1'b0;
  logic [2:0]    i_rd_sel = '0;
  logic          i_rec_ready = 1'b0;

  logic [15:0]   o_cnt_A, o_cnt_B, o_drop_cnt;
  logic          o_rec_valid, o_overflow;
  logic [RW-1:0] o_rec_data;
  logic [3:0]    cnt4_a, cnt4_b, drop4;
  logic          rec4_valid, ovf4;
  logic [RW-1:0] rec4_data;

  always #5 clk = ~clk;

  soft_error_event_logger dut (
    .i_clk(clk), .i_rst(i_rst), .i_err_A(i_err_A), .i_err_B(i_err_B),
    .i_clr(i_clr), .i_rd_sel(i_rd_sel), .o_cnt_A(o_cnt_A), .o_cnt_B(o_cnt_B),
    .o_rec_valid(o_rec_valid), .i_rec_ready(i_rec_ready), .o_rec_data(o_rec_data),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  soft_error_event_logger #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_err_A(i_err_A), .i_err_B(i_err_B),
    .i_clr(i_clr), .i_rd_sel(i_rd_sel), .o_cnt_A(cnt4_a), .o_cnt_B(cnt4_b),
    .o_rec_valid(rec4_valid), .i_rec_ready(i_rec_ready), .o_rec_data(rec4_data),
    .o_overflow(ovf4), .o_drop_cnt(drop4)
  );

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic [RW-1:0] exp_q [$];
  logic [TSW-1:0] m_ts;
  logic [N-1:0]  pa, pb, last_a, last_b;
`ifdef SOFT_ERR_GLITCH_FILTER_EN
  logic [N-1:0]  ppa, ppb;
`endif
  logic          m_vld1;
  logic [RW-1:0] m_rec1;
  int            m_occ, m_drop;
  logic          m_ovf;
  int            m_cnt_a [N];
  int            m_cnt_b [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // One clock cycle: apply flags, advance the model, step past the edge.
  task automatic cyc(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] ra, rb;
    logic pop_now;
    i_err_A = a; i_err_B = b; last_a = a; last_b = b;
`ifdef SOFT_ERR_GLITCH_FILTER_EN
    ra = a & pa & ~ppa;
    rb = b & pb & ~ppb;
    ppa = pa; ppb = pb;
`else
    ra = a & ~pa;
    rb = b & ~pb;
`endif
    pa = a; pb = b;
    pop_now = (m_occ > 0) && i_rec_ready;
    if (i_clr) begin
      for (int i = 0; i < N; i++) begin m_cnt_a[i] = 0; m_cnt_b[i] = 0; end
      m_ovf = 1'b0; m_drop = 0;
    end
    if (m_vld1) begin
      if (!i_clr)
        for (int i = 0; i < N; i++) begin
          if (m_rec1[i])   m_cnt_a[i]++;
          if (m_rec1[N+i]) m_cnt_b[i]++;
        end
      if (m_occ < DEPTH || pop_now) begin
        exp_q.push_back(m_rec1);
        m_occ++;
      end else if (!i_clr) begin
        m_ovf = 1'b1;
        m_drop++;
      end
    end
    if (pop_now) m_occ--;
    m_vld1 = |{ra, rb};
    m_rec1 = {m_ts, rb, ra};
    @(posedge clk); #1;
    m_ts = m_ts + 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc('0, '0);
  endtask

  task automatic do_reset(input logic [N-1:0] a);
    i_rst = 1'b0; i_clr = 1'b0;
    i_err_A = a; i_err_B = '0; last_a = a; last_b = '0;
    @(posedge clk); #1;
    i_rst = 1'b1;
    m_ts = '0; pa = '0; pb = '0;
`ifdef SOFT_ERR_GLITCH_FILTER_EN
    ppa = '0; ppb = '0;
`endif
    m_vld1 = 1'b0; m_rec1 = '0; m_occ = 0; m_ovf = 1'b0; m_drop = 0;
    for (int i = 0; i < N; i++) begin m_cnt_a[i] = 0; m_cnt_b[i] = 0; end
    exp_q.delete();
  endtask

  // Pulse one bank flag for PW cycles, then low for one cycle.
  task automatic toggle(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int k = 0; k < PW; k++) cyc(a, b);
    cyc('0, '0);
  endtask

  task automatic check_counts(input int bank);
    i_rd_sel = 3'(bank);
    cyc(last_a, last_b);
    chk("cnt_a", 64'(o_cnt_A), 64'(sat(m_cnt_a[bank], 65535)));
    chk("cnt_b", 64'(o_cnt_B), 64'(sat(m_cnt_b[bank], 65535)));
    chk("cnt4_a", 64'(cnt4_a), 64'(sat(m_cnt_a[bank], 15)));
    chk("cnt4_b", 64'(cnt4_b), 64'(sat(m_cnt_b[bank], 15)));
  endtask

  // Scoreboard: every record accepted by the consumer must match the model.
  always @(negedge clk) begin
    if (i_rst && o_rec_valid && i_rec_ready) begin
      if (exp_q.size() == 0) chk("rec_unexpected", 64'(o_rec_valid), 64'(0));
      else begin
        chk("rec_data", 64'(o_rec_data), 64'(exp_q[0]));
        chk("rec4_data", 64'(rec4_data), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [RW-1:0] first_rec;
    logic [TSW-1:0] ev_ts;

    // reset state
    do_reset('0);
    chk("rst_valid", 64'(o_rec_valid), 64'(0));
    chk("rst_data", 64'(o_rec_data), 64'(0));
    chk("rst_ovf", 64'(o_overflow), 64'(0));
    chk("rst_drop", 64'(o_drop_cnt), 64'(0));
    chk("rst_cnt_a", 64'(o_cnt_A), 64'(0));
    chk("rst_cnt_b", 64'(o_cnt_B), 64'(0));

    // single event on bank 2 A at ts=10, latency check
    i_rec_ready = 1'b0;
    while (m_ts < 10) cyc('0, '0);
    for (int k = 0; k < PW; k++) cyc(7'b0000100, '0);
    while (m_ts < 32'(10 + LAT - 1)) cyc('0, '0);
    chk("lat_early", 64'(o_rec_valid), 64'(0));
    cyc('0, '0);
    chk("lat_valid", 64'(o_rec_valid), 64'(1));
    ev_ts = 32'(10 + PW - 1);
    first_rec = {ev_ts, 7'b0000000, 7'b0000100};
    chk("first_rec", 64'(o_rec_data), 64'(first_rec));
    i_rec_ready = 1'b1;
    idle(3);
    check_counts(2);

    // simultaneous rise on A0 and B6, held for 50 cycles
    for (int k = 0; k < 50; k++) cyc(7'b0000001, 7'b1000000);
    idle(5);
    chk("held_drained", 64'(o_rec_valid), 64'(m_occ != 0));
    check_counts(0);
    check_counts(6);
    i_rd_sel = 3'd7;
    cyc('0, '0);
    chk("cnt_oob_a", 64'(o_cnt_A), 64'(0));
    chk("cnt_oob_b", 64'(o_cnt_B), 64'(0));

    // overflow: 20 events on bank 3 A with no consumer
    do_reset('0);
    i_rec_ready = 1'b0;
    for (int k = 0; k < 20; k++) toggle(7'b0001000, '0);
    idle(4);
    chk("ovf", 64'(o_overflow), 64'(m_ovf));
    chk("ovf_set", 64'(o_overflow), 64'(1));
    chk("drop", 64'(o_drop_cnt), 64'(m_drop));
    chk("drop_is4", 64'(o_drop_cnt), 64'(4));
    chk("drop4", 64'(drop4), 64'(m_drop));
    chk("full_valid", 64'(o_rec_valid), 64'(1));
    check_counts(3);
    i_rec_ready = 1'b1;
    idle(20);
    chk("ovf_drained", 64'(o_rec_valid), 64'(0));

    // saturation on bank 1 B, then clear with records parked in the FIFO
    do_reset('0);
    i_rec_ready = 1'b1;
    for (int k = 0; k < 20; k++) toggle('0, 7'b0000010);
    idle(4);
    check_counts(1);
    i_rec_ready = 1'b0;
    toggle(7'b0000001, '0);
    toggle(7'b0000001, '0);
    idle(4);
    i_rd_sel = 3'd1;
    i_clr = 1'b1;
    cyc('0, '0);
    i_clr = 1'b0;
    cyc('0, '0);
    chk("clr_cnt_b", 64'(o_cnt_B), 64'(0));
    chk("clr_cnt4_b", 64'(cnt4_b), 64'(0));
    chk("clr_fifo_kept", 64'(o_rec_valid), 64'(m_occ != 0));
    chk("clr_ovf", 64'(o_overflow), 64'(0));
    i_rec_ready = 1'b1;
    idle(6);

    // backpressure holds the head, then reset mid-operation
    i_rec_ready = 1'b0;
    for (int k = 0; k < 3; k++) toggle(7'b0010000, 7'b0010000);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      cyc('0, '0);
      chk("bp_valid", 64'(o_rec_valid), 64'(1));
      chk("bp_data", 64'(o_rec_data), 64'(exp_q[0]));
    end
    do_reset(7'b0010000);
    chk("mid_rst_valid", 64'(o_rec_valid), 64'(0));
    chk("mid_rst_cnt_a", 64'(o_cnt_A), 64'(0));
    chk("mid_rst_cnt_b", 64'(o_cnt_B), 64'(0));
    chk("mid_rst_drop", 64'(o_drop_cnt), 64'(0));
    // flag still high at release: counts as an edge, stamped near ts 0
    i_rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc(7'b0010000, '0);
    idle(4);
    check_counts(4);

    // short pulse vs. two-cycle pulse on bank 5 A
    cyc(7'b0100000, '0);
    idle(4);
    cyc(7'b0100000, '0);
    cyc(7'b0100000, '0);
    idle(5);
    check_counts(5);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/soft_error_event_logger.md
Name: soft_error_event_logger

Overview:
- Sits directly downstream of the per-bank soft-error hub; consumes its registered per-bank error_A/error_B flag vectors.
- Detects rising edges and keeps per-bank saturating event counters for channels A and B.
- Timestamps each cycle that contains at least one new event and queues it as a record in an internal FIFO.
- Drains records over a valid/ready stream to the readout logic (UART/host bridge).

Parameters:
- ERRSIG_ID_num, 7, number of banks (width of each error vector).
- TS_W, 32, free-running timestamp width.
- CNT_W, 16, width of each per-bank saturating event counter.
- FIFO_DEPTH, 16, record FIFO depth; power of two, at least 2.
- REC_W, TS_W+2*ERRSIG_ID_num, record width (derived; do not override).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-low reset.
- i_err_A  in  ERRSIG_ID_num  per-bank error flags, channel A.
- i_err_B  in  ERRSIG_ID_num  per-bank error flags, channel B.
- i_clr  in  1  synchronous clear of counters and sticky flags (active-high).
- i_rd_sel  in  $clog2(ERRSIG_ID_num)  bank index for counter readout.
- o_cnt_A  out  CNT_W  registered channel-A counter of bank i_rd_sel.
- o_cnt_B  out  CNT_W  registered channel-B counter of bank i_rd_sel.
- o_rec_valid  out  1  FIFO head record valid.
- i_rec_ready  in  1  consumer accepts the head record.
- o_rec_data  out  REC_W  record = {timestamp[TS_W-1:0], rise_B[N-1:0], rise_A[N-1:0]}.
- o_overflow  out  1  sticky; a record was dropped because the FIFO was full.
- o_drop_cnt  out  CNT_W  saturating count of dropped records.

Behaviour:
- Reset (i_rst==0 at a clock edge) sets the following to 0: timestamp, all counters, delayed inputs, FIFO pointers, o_rec_valid, o_rec_data, o_cnt_A, o_cnt_B, o_overflow and o_drop_cnt.
- Delayed inputs reset to 0, so an input that is already high when reset releases counts as a rising edge.
- Timestamp increments every cycle out of reset and wraps from 2^TS_W-1 to 0.
- Edge detect, cycle t: rise_X = i_err_X & ~err_X_d. err_X_d is registered, so rise is computed combinationally in cycle t.
- Stage 1, edge at end of cycle t: rise_A, rise_B and ts(t) are registered into a capture register with cap_valid = |{rise_A, rise_B}.
- Stage 2, edge at end of cycle t+1: if cap_valid, do the counter update and the FIFO push below.
  - Each counter with its rise bit set increments by 1, saturating at 2^CNT_W-1. There is no wrap.
  - The record is pushed if the FIFO is not full.
  - If the FIFO is full, the record is dropped, o_overflow is set and o_drop_cnt increments (saturating).
- Record visibility: o_rec_valid rises at cycle t+2 when the FIFO was empty, so edge-to-valid latency is 2 cycles.
- FIFO is first-word-fall-through: o_rec_data is stable while o_rec_valid && !i_rec_ready.
- Pop occurs on o_rec_valid && i_rec_ready.
- Simultaneous push and pop:
  - Allowed when the FIFO is full; no drop occurs in that case.
  - On an empty FIFO, the push wins and the record appears the next cycle. There is no bypass.
- Multiple banks or channels rising in the same cycle produce one record with several bits set. Every set bit increments its own counter.
- A held-high input generates exactly one event. A new event requires the input to go low for at least 1 cycle and then rise again.
- Readout: o_cnt_A/o_cnt_B are registered from the counters at index i_rd_sel, giving 1-cycle latency. An out-of-range i_rd_sel returns 0.
- i_clr:
  - Zeroes all counters, o_overflow and o_drop_cnt at the next edge.
  - Does not affect the FIFO, the timestamp or edge state.
  - A counter increment in the same cycle as i_clr is lost, because clear has priority.
- Reset mid-operation discards FIFO contents and any in-flight capture. o_rec_valid drops the cycle after the reset edge.

Optional Feature:
- Macro: SOFT_ERR_GLITCH_FILTER_EN.
- Defined:
  - A rising edge qualifies only if the input is high in two consecutive cycles (i_err & err_d & ~err_dd).
  - A 1-cycle pulse is ignored.
  - Edge-to-valid latency becomes 3 cycles.
  - The recorded timestamp is that of the second high cycle.
- Undefined: 1-cycle pulses count, with the latency given above.

Test Plan:
- Single event: after reset, i_err_A=7'b0000100 held 1 cycle at ts=10 -> record {ts=10, B=0, A=0000100} with o_rec_valid at ts=12; bank-2 A counter =1.
- Simultaneous and held: i_err_A[0]=1, i_err_B[6]=1 both rise at the same cycle and are held 50 cycles -> exactly one record with A=0000001 and B=1000000; each counter =1.
- Overflow: i_rec_ready=0, 20 separate toggles on bank 3 A with FIFO_DEPTH=16 -> 16 records retained, o_overflow=1, o_drop_cnt=4, bank-3 A counter=20. Then hold i_rec_ready=1 -> 16 records in timestamp order.
- Saturation and clear: CNT_W=4, 20 events on bank 1 B -> o_cnt_B=15 with i_rd_sel=1; pulse i_clr -> o_cnt_B=0 two cycles later, FIFO untouched.
- Backpressure and reset: FIFO holding 3 records, i_rec_ready=0 -> o_rec_data stable; assert i_rst=0 one cycle -> o_rec_valid=0, all counters and the timestamp at 0.
- With SOFT_ERR_GLITCH_FILTER_EN: a 1-cycle pulse on bank 5 A -> no record and counter 0; a 2-cycle pulse -> one record, valid 3 cycles after the rise.
